// File: rtl/fetch_ctrl_if.sv
// Fetch control bundle: stall/redirect requests in, PC steering and perf counters out.
// The slave modport is the fetch_ctrl side; master is the pipeline/bench side.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             icache_stall;
  logic             dcache_stall;
  logic             redirect;
  logic             clr_cnt;
  logic             pc_stall;
  logic             pc_sel;
  logic             flush;
  logic             pipe_stall;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output icache_stall, dcache_stall, redirect, clr_cnt,
    input  pc_stall, pc_sel, flush, pipe_stall, state, stall_cycles, redirect_cnt
  );

  modport slave (
    input  icache_stall, dcache_stall, redirect, clr_cnt,
    output pc_stall, pc_sel, flush, pipe_stall, state, stall_cycles, redirect_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC steering FSM: stall/select/flush are combinational from state and inputs (0-cycle), applied at the next edge.
// A redirect arriving during a memory stall is parked in PEND and replayed once the stall clears.
module fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    PEND = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic             mem_stall;
  logic             pc_stall;
  logic             pc_sel;
  logic             flush;

  assign mem_stall = bus.icache_stall | bus.dcache_stall;

  always_comb begin
    state_d  = state_q;
    pc_stall = 1'b1;
    pc_sel   = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      BOOT: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN, HOLD: begin
        if (mem_stall) begin
          state_d = bus.redirect ? PEND : HOLD;
        end else begin
          pc_stall = 1'b0;
          pc_sel   = bus.redirect;
          flush    = bus.redirect;
          state_d  = RUN;
        end
      end
      PEND: begin
        // The target is still held by stage2, so the redirect input itself is ignored here.
        if (!mem_stall) begin
          pc_stall = 1'b0;
          pc_sel   = 1'b1;
          flush    = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirect_cnt_d = redirect_cnt_q;
    if (bus.clr_cnt) begin
      stall_cycles_d = '0;
      redirect_cnt_d = '0;
    end else begin
      if (pc_stall && (state_q != BOOT) && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + CNT_ONE;
      end
      if (pc_sel && !pc_stall && (redirect_cnt_q != '1)) begin
        redirect_cnt_d = redirect_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= BOOT;
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.pc_sel       = pc_sel;
  assign bus.flush        = flush;
  assign bus.pipe_stall   = mem_stall;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenario tasks plus randomized traffic against a flag-based reference model.
// Two instances (16-bit and 4-bit counters) share the same stimulus.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_stall = 1'b0;
  logic dcache_stall = 1'b0;
  logic redirect = 1'b0;
  logic clr_cnt = 1'b0;

  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.CNT_W(16)) bus16 ();
  fetch_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus16.icache_stall = icache_stall;
  assign bus16.dcache_stall = dcache_stall;
  assign bus16.redirect     = redirect;
  assign bus16.clr_cnt      = clr_cnt;
  assign bus4.icache_stall  = icache_stall;
  assign bus4.dcache_stall  = dcache_stall;
  assign bus4.redirect      = redirect;
  assign bus4.clr_cnt       = clr_cnt;

  fetch_ctrl #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus16));
  fetch_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .reset(reset), .bus(bus4));

  // Reference model: booting / stalled-last-cycle / redirect-owed flags and integer counters.
  bit m_boot = 1'b1;
  bit m_held = 1'b0;
  bit m_pend = 1'b0;
  int m_stall16 = 0, m_redir16 = 0, m_stall4 = 0, m_redir4 = 0;
  logic e_stall, e_sel, e_flush, e_mem;
  logic [1:0] e_state;

  always_comb begin
    e_mem   = icache_stall | dcache_stall;
    e_stall = 1'b1;
    e_sel   = 1'b0;
    e_flush = 1'b0;
    if (m_boot) begin
      e_flush = 1'b1;
    end else if (!e_mem) begin
      e_stall = 1'b0;
      e_sel   = m_pend | redirect;
      e_flush = m_pend | redirect;
    end
    e_state = m_boot ? 2'd0 : (m_pend ? 2'd3 : (m_held ? 2'd2 : 2'd1));
  end

  function automatic int bump(input int v, input bit inc, input bit clr, input int max);
    if (clr) return 0;
    if (inc && v < max) return v + 1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_boot <= 1'b1; m_held <= 1'b0; m_pend <= 1'b0;
      m_stall16 <= 0; m_redir16 <= 0; m_stall4 <= 0; m_redir4 <= 0;
    end else begin
      m_boot <= 1'b0;
      m_held <= !m_boot && e_mem;
      m_pend <= !m_boot && e_mem && (m_pend || redirect);
      m_stall16 <= bump(m_stall16, e_stall && !m_boot, clr_cnt, 65535);
      m_stall4  <= bump(m_stall4,  e_stall && !m_boot, clr_cnt, 15);
      m_redir16 <= bump(m_redir16, e_sel && !e_stall, clr_cnt, 65535);
      m_redir4  <= bump(m_redir4,  e_sel && !e_stall, clr_cnt, 15);
    end
  end

  always @(negedge clk) begin
    if (sb_en && !reset) begin
      checks++;
      if ({bus16.state, bus16.pc_stall, bus16.pc_sel, bus16.flush, bus16.pipe_stall} !==
          {e_state, e_stall, e_sel, e_flush, e_mem}) begin
        failures++;
        $display("FAIL sb_ctrl16 t=%0t got st=%0d stl=%b sel=%b fl=%b ps=%b want st=%0d stl=%b sel=%b fl=%b ps=%b",
                 $time, bus16.state, bus16.pc_stall, bus16.pc_sel, bus16.flush, bus16.pipe_stall,
                 e_state, e_stall, e_sel, e_flush, e_mem);
      end
      checks++;
      if ({bus4.state, bus4.pc_stall, bus4.pc_sel, bus4.flush} !== {e_state, e_stall, e_sel, e_flush}) begin
        failures++;
        $display("FAIL sb_ctrl4 t=%0t got st=%0d stl=%b sel=%b fl=%b want st=%0d stl=%b sel=%b fl=%b",
                 $time, bus4.state, bus4.pc_stall, bus4.pc_sel, bus4.flush, e_state, e_stall, e_sel, e_flush);
      end
      checks++;
      if (bus16.stall_cycles !== 16'(m_stall16) || bus16.redirect_cnt !== 16'(m_redir16)) begin
        failures++;
        $display("FAIL sb_cnt16 t=%0t got stall=%0d redir=%0d want stall=%0d redir=%0d",
                 $time, bus16.stall_cycles, bus16.redirect_cnt, m_stall16, m_redir16);
      end
      checks++;
      if (bus4.stall_cycles !== 4'(m_stall4) || bus4.redirect_cnt !== 4'(m_redir4)) begin
        failures++;
        $display("FAIL sb_cnt4 t=%0t got stall=%0d redir=%0d want stall=%0d redir=%0d",
                 $time, bus4.stall_cycles, bus4.redirect_cnt, m_stall4, m_redir4);
      end
    end
  end

  task automatic drive(input logic ic, input logic dc, input logic rd, input logic clr, input logic rst);
    icache_stall = ic; dcache_stall = dc; redirect = rd; clr_cnt = clr; reset = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1); tick(); tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({bus16.state, bus16.pc_stall, bus16.pc_sel, bus16.flush} !== {2'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL boot_cycle0 got st=%0d stl=%b sel=%b fl=%b want st=0 stl=1 sel=0 fl=1",
               bus16.state, bus16.pc_stall, bus16.pc_sel, bus16.flush);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus16.state, bus16.pc_stall, bus16.pc_sel} !== {2'd1, 1'b0, 1'b0} || bus16.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL boot_cycle1 got st=%0d stl=%b sel=%b stall_cycles=%0d want st=1 stl=0 sel=0 stall_cycles=0",
               bus16.state, bus16.pc_stall, bus16.pc_sel, bus16.stall_cycles);
    end
    tick();
  endtask

  task automatic test_redirect_run();
    clear_counters();
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if ({bus16.pc_sel, bus16.flush, bus16.pc_stall, bus16.state} !== {1'b1, 1'b1, 1'b0, 2'd1} ||
        bus16.redirect_cnt !== 16'd0) begin
      failures++;
      $display("FAIL redirect_run got sel=%b fl=%b stl=%b st=%0d cnt=%0d want sel=1 fl=1 stl=0 st=1 cnt=0",
               bus16.pc_sel, bus16.flush, bus16.pc_stall, bus16.state, bus16.redirect_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus16.redirect_cnt !== 16'd1 || bus16.state !== 2'd1) begin
      failures++;
      $display("FAIL redirect_run_cnt got cnt=%0d st=%0d want cnt=1 st=1", bus16.redirect_cnt, bus16.state);
    end
    tick();
  endtask

  task automatic test_stall_redirect();
    logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       rd_seq [3] = '{1'b0, 1'b1, 1'b0};
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 0, rd_seq[i], 0, 0);
      else       drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (bus16.state !== exp_st[i]) begin
        failures++;
        $display("FAIL stall_redirect_state step=%0d got st=%0d want st=%0d", i, bus16.state, exp_st[i]);
      end
      if (i == 3) begin
        checks++;
        if ({bus16.pc_sel, bus16.flush, bus16.pc_stall} !== 3'b110) begin
          failures++;
          $display("FAIL stall_redirect_release got sel=%b fl=%b stl=%b want sel=1 fl=1 stl=0",
                   bus16.pc_sel, bus16.flush, bus16.pc_stall);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus16.state !== 2'd1 || bus16.stall_cycles !== 16'd3 || bus16.redirect_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stall_redirect_cnt got st=%0d stall=%0d redir=%0d want st=1 stall=3 redir=1",
               bus16.state, bus16.stall_cycles, bus16.redirect_cnt);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    clear_counters();
    drive(0, 1, 1, 0, 0);
    @(negedge clk);
    checks++;
    if ({bus16.pc_stall, bus16.flush, bus16.pc_sel} !== 3'b100) begin
      failures++;
      $display("FAIL simul_stall got stl=%b fl=%b sel=%b want stl=1 fl=0 sel=0",
               bus16.pc_stall, bus16.flush, bus16.pc_sel);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus16.state !== 2'd3 || {bus16.pc_sel, bus16.flush} !== 2'b11) begin
      failures++;
      $display("FAIL simul_release got st=%0d sel=%b fl=%b want st=3 sel=1 fl=1", bus16.state, bus16.pc_sel, bus16.flush);
    end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (bus16.redirect_cnt !== 16'd1 || bus16.pc_sel !== 1'b0 || bus16.state !== 2'd1) begin
      failures++;
      $display("FAIL simul_once got redir=%0d sel=%b st=%0d want redir=1 sel=0 st=1",
               bus16.redirect_cnt, bus16.pc_sel, bus16.state);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_counters();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    checks++;
    if (bus4.stall_cycles !== 4'd15 || bus16.stall_cycles !== 16'd20) begin
      failures++;
      $display("FAIL saturate got stall4=%0d stall16=%0d want stall4=15 stall16=20", bus4.stall_cycles, bus16.stall_cycles);
    end
    drive(1, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus4.stall_cycles !== 4'd0 || bus16.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL clr_priority got stall4=%0d stall16=%0d want 0 and 0", bus4.stall_cycles, bus16.stall_cycles);
    end
    tick();
    drive(0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_in_pend();
    clear_counters();
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus16.state !== 2'd3) begin
      failures++;
      $display("FAIL pend_entry got st=%0d want st=3", bus16.state);
    end
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus16.state !== 2'd0 || bus16.pc_sel !== 1'b0) begin
      failures++;
      $display("FAIL pend_reset_boot got st=%0d sel=%b want st=0 sel=0", bus16.state, bus16.pc_sel);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus16.state !== 2'd1 || bus16.pc_sel !== 1'b0 || bus16.redirect_cnt !== 16'd0) begin
      failures++;
      $display("FAIL pend_reset_run got st=%0d sel=%b redir=%0d want st=1 sel=0 redir=0",
               bus16.state, bus16.pc_sel, bus16.redirect_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
            $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    test_reset();
    sb_en = 1'b1;
    test_redirect_run();
    test_stall_redirect();
    test_simultaneous();
    test_saturation();
    test_reset_in_pend();
    test_random();
    sb_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the performance counters.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 icache_stall  input  1  instruction cache not ready this cycle.
REQ-005 dcache_stall  input  1  data cache not ready this cycle.
REQ-006 redirect  input  1  stage2 requests the next PC = alu_out (taken branch or jump).
REQ-007 clr_cnt  input  1  synchronous clear of both counters.
REQ-008 pc_stall  output  1  drives PC stall.
REQ-009 pc_sel  output  1  drives PC select: 0 = PC+4, 1 = alu_out.
REQ-010 flush  output  1  squashes the instruction in the stage1/stage2 register.
REQ-011 pipe_stall  output  1  freezes the pipeline registers; equals icache_stall | dcache_stall.
REQ-012 state  output  2  current FSM state.
REQ-013 stall_cycles  output  CNT_W  count of cycles with PC held.
REQ-014 redirect_cnt  output  CNT_W  count of redirects applied.

Function
REQ-015 mem_stall = icache_stall | dcache_stall.
REQ-016 States SHALL be BOOT=2'b00, RUN=2'b01, HOLD=2'b10, PEND=2'b11, held in a register.
REQ-017 pc_stall, pc_sel and flush SHALL be combinational from state and the current-cycle inputs; the PC consumes them at the next rising edge.
REQ-018 BOOT outputs: pc_stall=1, pc_sel=0, flush=1. The next state SHALL be RUN unconditionally. BOOT lasts exactly one cycle after reset deasserts, so the fetch at PC_RESET completes before the PC advances.
REQ-019 RUN with mem_stall=0: pc_stall=0, pc_sel=redirect, flush=redirect. The FSM SHALL stay in RUN.
REQ-020 RUN with mem_stall=1: pc_stall=1, pc_sel=0, flush=0. The next state SHALL be PEND if redirect=1, else HOLD.
REQ-021 HOLD with mem_stall=1: pc_stall=1, pc_sel=0, flush=0. The next state SHALL be PEND if redirect=1, else HOLD.
REQ-022 HOLD with mem_stall=0: pc_stall=0, pc_sel=redirect, flush=redirect. The next state SHALL be RUN.
REQ-023 PEND with mem_stall=1: pc_stall=1, pc_sel=0, flush=0. The FSM SHALL stay in PEND.
REQ-024 PEND with mem_stall=0: pc_stall=0, pc_sel=1, flush=1, regardless of redirect. The next state SHALL be RUN.
REQ-025 A redirect latched in PEND SHALL be applied exactly once. While in PEND, the redirect input SHALL be ignored.
REQ-026 Stage2 holds alu_out stable while pipe_stall=1. This block SHALL NOT store the redirect target.
REQ-027 stall_cycles SHALL increment by 1 on each edge where pc_stall=1 and state!=BOOT.
REQ-028 redirect_cnt SHALL increment by 1 on each edge where pc_sel=1 and pc_stall=0.
REQ-029 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 clr_cnt=1 SHALL zero both counters at the next edge and SHALL take priority over a simultaneous increment.
REQ-031 flush=1 SHALL imply pc_sel=1, except in BOOT.
REQ-032 pc_stall=0 and flush=1 SHALL never both hold while mem_stall=1.

Reset
REQ-033 reset=1 at an edge SHALL force state=BOOT and stall_cycles=0, redirect_cnt=0, overriding all other inputs.
REQ-034 While state=BOOT the outputs SHALL be pc_stall=1, pc_sel=0, flush=1, with pipe_stall following REQ-011.
REQ-035 Reset asserted mid-stall or in PEND SHALL discard any pending redirect; no redirect SHALL be applied after reset.

Verification
REQ-036 Boot: reset high 2 cycles, then low, no stalls -> cycle 0 shows state=BOOT, pc_stall=1, flush=1; cycle 1 shows state=RUN, pc_stall=0, pc_sel=0; stall_cycles=0.
REQ-037 Redirect in RUN: redirect=1 for one cycle, no stall -> that cycle pc_sel=1, flush=1, pc_stall=0; redirect_cnt 0->1; state stays RUN.
REQ-038 Stall then redirect: icache_stall=1 for 3 cycles with redirect=1 in the 2nd stall cycle, then redirect=0 -> states RUN->HOLD->PEND->PEND->RUN. The first cycle with icache_stall=0 shows pc_sel=1, flush=1. Counters read stall_cycles=3 and redirect_cnt=1.
REQ-039 Simultaneous events: dcache_stall=1 and redirect=1 in the same RUN cycle -> pc_stall=1, flush=0, next state PEND. On release, exactly one redirect is applied.
REQ-040 Saturation and clear: CNT_W=4, hold icache_stall=1 for 20 cycles -> stall_cycles reaches 15 and stays 15. Then clr_cnt=1 together with a stall cycle -> stall_cycles=0 next cycle.
REQ-041 Reset in PEND: enter PEND, assert reset for 1 cycle, then release with stalls clear -> BOOT then RUN with pc_sel=0; redirect_cnt=0.
